// File: rtl/ipv_reducer_mc.sv
// ipv_reducer_mc: multi-channel ipv frame reducer.
// Per-channel ones count, thermometer code and majority flag after a fixed latency.
module ipv_reducer_mc #(
  parameter int CH    = 4,
  parameter int K     = 4,
  parameter int STALL = 3,
  parameter int THR   = K / 2 + 1,
  localparam int CW   = $clog2(K + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            frame_start,
  input  logic [CH-1:0]   ipv_in,
  output logic            out_valid,
  output logic [CH*K-1:0] vov,
  output logic [CH*CW-1:0] cnt,
  output logic [CH-1:0]   maj
);

  localparam int BW = $clog2(K);

  logic [BW-1:0]    beat_q;
  logic [CH*CW-1:0] acc_q;
  logic [CH*CW-1:0] load;
  logic [CH*CW-1:0] sum;
  logic             last;

  logic [CH*CW-1:0] pd_q [STALL];
  logic [STALL-1:0] pv_q;

  // Fresh-load and running-sum values for every channel
  always_comb begin
    load = '0;
    sum  = '0;
    for (int c = 0; c < CH; c++) begin
      load[c*CW +: CW] = CW'(ipv_in[c]);
      sum[c*CW +: CW]  = acc_q[c*CW +: CW] + CW'(ipv_in[c]);
    end
    last = in_valid && !frame_start && (beat_q == BW'(K - 1));
  end

  // Beat counter and per-channel accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      acc_q  <= '0;
    end else if (in_valid) begin
      if (frame_start || beat_q == '0) begin
        beat_q <= BW'(1);
        acc_q  <= load;
      end else begin
        acc_q  <= sum;
        beat_q <= last ? '0 : beat_q + 1'b1;
      end
    end else if (frame_start) begin
      beat_q <= '0;
    end
  end

  // Result pipeline, advances every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      for (int s = 0; s < STALL; s++) pd_q[s] <= '0;
    end else begin
      pv_q[0] <= last;
      pd_q[0] <= sum;
      for (int s = 1; s < STALL; s++) begin
        pv_q[s] <= pv_q[s-1];
        pd_q[s] <= pd_q[s-1];
      end
    end
  end

  // Output decode from the last stage, zeroed when not valid
  always_comb begin
    logic [CW-1:0] n;
    n         = '0;
    out_valid = pv_q[STALL-1];
    vov       = '0;
    cnt       = '0;
    maj       = '0;
    for (int c = 0; c < CH; c++) begin
      n = pd_q[STALL-1][c*CW +: CW];
      if (out_valid) begin
        cnt[c*CW +: CW] = n;
        maj[c]          = (int'(n) >= THR);
        for (int i = 0; i < K; i++) begin
          vov[c*K + i] = (int'(n) + i >= K);
        end
      end
    end
  end

endmodule

// File: tb/tb_ipv_reducer_mc.sv
// tb_ipv_reducer_mc: several parameter sets driven by shared stimulus.
// Each instance has its own frame-queue reference model and scoreboard.
module tb_ipv_reducer_mc;

  localparam int NC = 4;
  localparam int P_CH [NC] = '{4, 1, 3, 16};
  localparam int P_K  [NC] = '{4, 2, 16, 3};
  localparam int P_S  [NC] = '{3, 1, 8, 5};
  localparam int P_T  [NC] = '{3, 2, 9, 3};

  typedef struct packed {
    logic [63:0] due;
    logic [79:0] c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] ipv = '0;
  logic        drain = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : cfg
    localparam int C  = P_CH[g];
    localparam int KK = P_K[g];
    localparam int S  = P_S[g];
    localparam int TH = P_T[g];
    localparam int CWG = $clog2(KK + 1);

    logic            ov;
    logic [C*KK-1:0]  vov;
    logic [C*CWG-1:0] cnt;
    logic [C-1:0]     maj;

    ipv_reducer_mc #(.CH(C), .K(KK), .STALL(S), .THR(TH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .frame_start(frame_start),
      .ipv_in(ipv[C-1:0]),
      .out_valid(ov),
      .vov(vov),
      .cnt(cnt),
      .maj(maj)
    );

    logic [15:0] frame [$];
    exp_t        sb [$];

    // Reference: collect whole frames, popcount each channel at completion
    always @(posedge clk or negedge rst_n) begin
      exp_t e;
      int   n;
      if (!rst_n) begin
        frame.delete();
        sb.delete();
      end else begin
        if (frame_start) frame.delete();
        if (in_valid) begin
          frame.push_back(ipv);
          if (frame.size() == KK) begin
            e.due = $time + 64'((S - 1) * 10);
            e.c   = '0;
            for (int ch = 0; ch < C; ch++) begin
              n = 0;
              foreach (frame[b]) n += int'(frame[b][ch]);
              e.c[ch*5 +: 5] = 5'(n);
            end
            sb.push_back(e);
            frame.delete();
          end
        end
      end
    end

    // Monitor: compare every cycle against the scoreboard
    always @(negedge clk) begin
      exp_t e;
      int   n;
      logic [C*KK-1:0]  xv;
      logic [C*CWG-1:0] xc;
      logic [C-1:0]     xm;
      if (drain) begin
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL cfg%0d drain: %0d results outstanding, required 0",
                   g, sb.size());
        end
      end
      if (ov) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL cfg%0d spurious_valid at %0t: out_valid=1 required 0",
                   g, $time);
        end else begin
          e  = sb.pop_front();
          xv = '0;
          xc = '0;
          xm = '0;
          for (int ch = 0; ch < C; ch++) begin
            n = int'(e.c[ch*5 +: 5]);
            xc[ch*CWG +: CWG] = CWG'(n);
            xv[ch*KK +: KK]   = KK'(((1 << n) - 1) << (KK - n));
            xm[ch]            = (n >= TH);
          end
          if (e.due + 5 != $time) begin
            errors++;
            $display("FAIL cfg%0d latency: strobe at %0t required %0t",
                     g, $time, e.due + 5);
          end
          checks += 3;
          if (cnt !== xc) begin
            errors++;
            $display("FAIL cfg%0d cnt: got %h required %h", g, cnt, xc);
          end
          if (vov !== xv) begin
            errors++;
            $display("FAIL cfg%0d vov: got %h required %h", g, vov, xv);
          end
          if (maj !== xm) begin
            errors++;
            $display("FAIL cfg%0d maj: got %h required %h", g, maj, xm);
          end
        end
      end else begin
        checks++;
        if (vov !== '0 || cnt !== '0 || maj !== '0) begin
          errors++;
          $display("FAIL cfg%0d idle_zero: vov=%h cnt=%h maj=%h required 0",
                   g, vov, cnt, maj);
        end
        if (sb.size() > 0 && sb[0].due + 5 <= $time) begin
          e = sb.pop_front();
          errors++;
          $display("FAIL cfg%0d missing_valid: out_valid=0 required 1 at %0t",
                   g, e.due + 5);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic fs, input logic [15:0] b);
    @(negedge clk);
    #1;
    in_valid    = v;
    frame_start = fs;
    ipv         = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0);
  endtask

  function automatic logic [15:0] rnd();
    return 16'($urandom);
  endfunction

  function automatic logic [15:0] rbit(input logic b0);
    logic [15:0] r;
    r    = rnd();
    r[0] = b0;
    return r;
  endfunction

  task automatic frame4(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
    drive(1'b1, 1'b1, a);
    drive(1'b1, 1'b0, b);
    drive(1'b1, 1'b0, c);
    drive(1'b1, 1'b0, d);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Channel 0 bits 1,0,1,1 on default instance
    frame4(rbit(1'b1), rbit(1'b0), rbit(1'b1), rbit(1'b1));
    idle(1);
    @(negedge clk);
    #1 chk("early_valid", 64'(cfg[0].ov), 64'd0);
    @(negedge clk);
    #1;
    chk("ch0_valid", 64'(cfg[0].ov), 64'd1);
    chk("ch0_vov", 64'(cfg[0].vov[3:0]), 64'b1110);
    chk("ch0_cnt", 64'(cfg[0].cnt[2:0]), 64'd3);
    chk("ch0_maj", 64'(cfg[0].maj[0]), 64'd1);
    idle(4);

    // All ones then all zeros, back to back
    frame4(16'hffff, 16'hffff, 16'hffff, 16'hffff);
    frame4(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    idle(12);

    // Idle gap inside a frame
    drive(1'b1, 1'b1, rnd());
    drive(1'b1, 1'b0, rnd());
    idle(2);
    drive(1'b1, 1'b0, rnd());
    drive(1'b1, 1'b0, rnd());
    idle(10);

    // Restart on beat 3
    drive(1'b1, 1'b1, rnd());
    drive(1'b1, 1'b0, rnd());
    frame4(rnd(), rnd(), rnd(), rnd());
    idle(10);

    // Restart on the would-be final beat
    drive(1'b1, 1'b1, rnd());
    drive(1'b1, 1'b0, rnd());
    drive(1'b1, 1'b0, rnd());
    frame4(rnd(), rnd(), rnd(), rnd());
    idle(10);

    // frame_start without in_valid mid-frame
    drive(1'b1, 1'b1, rnd());
    drive(1'b1, 1'b0, rnd());
    drive(1'b0, 1'b1, '0);
    repeat (4) drive(1'b1, 1'b0, rnd());
    idle(10);

    // Reset one cycle after a completed frame
    frame4(rnd(), rnd(), rnd(), rnd());
    drive(1'b0, 1'b0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    frame4(rnd(), rnd(), rnd(), rnd());
    idle(12);

    // Long saturating runs so wide frames reach full and empty counts
    drive(1'b1, 1'b1, 16'hffff);
    repeat (19) drive(1'b1, 1'b0, 16'hffff);
    drive(1'b1, 1'b1, 16'h0000);
    repeat (19) drive(1'b1, 1'b0, 16'h0000);
    idle(12);

    // Randomized traffic with occasional realignment and reset
    for (int i = 0; i < 3000; i++) begin
      int m;
      logic [15:0] b;
      if ($urandom_range(0, 499) == 0) begin
        drive(1'b0, 1'b0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
      m = int'($urandom_range(0, 7));
      b = (m == 0) ? 16'hffff : (m == 1) ? 16'h0000 : rnd();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, b);
    end

    idle(30);
    @(negedge clk);
    #1 drain = 1'b1;
    @(negedge clk);
    #1 drain = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ipv_reducer_mc.md
IPV_REDUCER_MC -- requirements
Module: ipv_reducer_mc

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent ipv channels, 1..16.
REQ-002 SHALL have parameter K, default 4: beats per frame, 2..16.
REQ-003 SHALL have parameter STALL, default 3: output pipeline depth in clk cycles, 1..8.
REQ-004 SHALL have parameter THR, default K/2+1: majority threshold, 1..K.
REQ-005 SHALL define local width CW = clog2(K+1) for the per-channel count field.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 in_valid  input  1  qualifies ipv_in and frame_start for the current cycle.
REQ-009 frame_start  input  1  synchronous frame realignment strobe.
REQ-010 ipv_in  input  CH  one ipv bit per channel; bit c belongs to channel c.
REQ-011 out_valid  output  1  one-cycle strobe marking a completed-frame result.
REQ-012 vov  output  CH*K  per-channel thermometer code; channel c occupies bits [c*K+K-1 : c*K].
REQ-013 cnt  output  CH*CW  per-channel binary count of ones; channel c occupies bits [c*CW+CW-1 : c*CW].
REQ-014 maj  output  CH  per-channel flag: count >= THR.

Function
REQ-015 SHALL keep a beat counter 0..K-1 that advances only on cycles with in_valid=1; idle cycles hold counter and accumulators.
REQ-016 Beat at counter 0 SHALL clear each channel accumulator and load that beat's bit; later beats SHALL add the bit.
REQ-017 Thermometer fill SHALL be MSB-first: a channel with n ones has vov bits [K-1 : K-n] set and all lower bits clear; n=0 gives all zeros, n=K gives all ones.
REQ-018 On the beat with counter K-1 and in_valid=1, the counter SHALL wrap to 0 and the frame result SHALL be captured into pipeline stage 0 with a valid tag; the result includes that final beat.
REQ-019 Pipeline SHALL advance every clk cycle regardless of in_valid; out_valid SHALL rise exactly STALL cycles after the cycle in which the completing beat was sampled.
REQ-020 When out_valid=0, vov, cnt and maj SHALL all be driven to zero.
REQ-021 frame_start=1 with in_valid=1 SHALL discard any partial frame, produce no result for it, and treat the current beat as counter 0.
REQ-022 frame_start=1 with in_valid=0 SHALL discard any partial frame and set the counter to 0.
REQ-023 frame_start on a beat that would be K-1 SHALL take precedence: the beat starts a new frame and no result is captured.
REQ-024 Back-to-back frames with no idle cycles SHALL produce out_valid strobes exactly K cycles apart, with no lost or merged results.
REQ-025 Channels SHALL be fully independent; the counter, frame_start and out_valid are shared by all channels.
REQ-026 cnt SHALL never exceed K; maj SHALL equal (cnt >= THR) for the same channel and cycle.

Reset
REQ-027 rst_n low SHALL clear the counter, all accumulators and all pipeline stages, including valid tags, immediately and asynchronously.
REQ-028 While rst_n is low and on the first cycle after release, out_valid, vov, cnt and maj SHALL be 0.
REQ-029 Reset asserted mid-frame or with results in flight SHALL drop them; no out_valid SHALL appear for pre-reset data.

Verification
REQ-030 Defaults (CH=4, K=4, STALL=3), continuous in_valid, channel 0 bits 1,0,1,1 -> out_valid pulses 3 cycles after beat 4; vov ch0 = 4'b1110, cnt ch0 = 3, maj ch0 = 1.
REQ-031 All channels all-ones for one frame, then all-zeros for the next, no gaps -> strobes 4 cycles apart; first strobe gives vov = all ones and cnt = 4 per channel; second gives all zeros and cnt = 0.
REQ-032 Frame with 2 idle cycles inserted between beats 2 and 3 -> result identical to the gap-free frame; out_valid 3 cycles after the final valid beat.
REQ-033 frame_start with in_valid on beat 3 of a frame -> no strobe for the aborted frame; next strobe follows 3 further valid beats after the restart beat, plus STALL cycles.
REQ-034 rst_n pulsed low 1 cycle after the final beat of a frame -> out_valid stays 0; the next full frame produces a correct strobe.
REQ-035 Parameter sweep: K=2, K=16, STALL=1, STALL=8, CH=1 -> latency equals STALL, and cnt, vov and maj match a reference popcount model for random stimulus.
